// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue merging ALU and memory/mul-div results onto one register-file write port.
// Define WB_QUEUE_FWD_EN to drive fwd_data1/fwd_data2 with the youngest pending value (otherwise tied to 0).
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_reg,
    input  logic [31:0]             alu_data,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [4:0]              mem_reg,
    input  logic [31:0]             mem_data,
    output logic                    mem_ready,
    output logic                    RegWrite,
    output logic [4:0]              WriteReg,
    output logic [31:0]             WriteData,
    input  logic [4:0]              q_reg1,
    input  logic [4:0]              q_reg2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [31:0]             fwd_data1,
    output logic [31:0]             fwd_data2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_ALMOST = CW'(DEPTH - 1);

    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_alu_acc;
    logic          w_mem_acc;
    logic          w_alu_st;
    logic          w_mem_st;
    logic          w_deq;
    logic [AW-1:0] w_mem_idx;
    logic [AW-1:0] w_idx  [DEPTH];
    logic          w_live [DEPTH];

    assign count     = r_count;
    assign alu_ready = (r_count < C_DEPTH);
    // mem must leave room for a same-cycle ALU entry, which is always the older one.
    assign mem_ready = (r_count < C_ALMOST) || ((r_count == C_ALMOST) && !alu_valid);

    assign w_alu_acc = alu_valid && alu_ready && !rst;
    assign w_mem_acc = mem_valid && mem_ready && !rst;
    assign w_alu_st  = w_alu_acc && (alu_reg != 5'd0);
    assign w_mem_st  = w_mem_acc && (mem_reg != 5'd0);
    assign w_deq     = (r_count != '0) && !rst;
    assign w_mem_idx = r_tail + AW'(w_alu_st);

    assign RegWrite  = w_deq;
    assign WriteReg  = w_deq ? r_reg[r_head]  : 5'd0;
    assign WriteData = w_deq ? r_data[r_head] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_deq);
            r_tail  <= r_tail + AW'(w_alu_st) + AW'(w_mem_st);
            r_count <= r_count + CW'(w_alu_st) + CW'(w_mem_st) - CW'(w_deq);
        end
    end

    // NOTE: entry storage is not reset; only slots inside head..head+count are ever observed.
    always_ff @(posedge clk) begin
        if (w_alu_st) begin
            r_reg[r_tail]  <= alu_reg;
            r_data[r_tail] <= alu_data;
        end
        if (w_mem_st) begin
            r_reg[w_mem_idx]  <= mem_reg;
            r_data[w_mem_idx] <= mem_data;
        end
    end

    // Slot k holds the k-th oldest entry; it is live when k < count.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_idx[k]  = r_head + AW'(k);
            w_live[k] = (CW'(k) < r_count);
        end
    end

`ifdef WB_QUEUE_FWD_EN
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = 32'd0;
        fwd_data2 = 32'd0;
        // Scan oldest to youngest so the last match wins.
        for (int k = 0; k < DEPTH; k++) begin
            if (w_live[k] && (q_reg1 != 5'd0) && (r_reg[w_idx[k]] == q_reg1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = r_data[w_idx[k]];
            end
            if (w_live[k] && (q_reg2 != 5'd0) && (r_reg[w_idx[k]] == q_reg2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = r_data[w_idx[k]];
            end
        end
    end
`else
    always_comb begin
        fwd_hit1 = 1'b0;
        fwd_hit2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_live[k] && (q_reg1 != 5'd0) && (r_reg[w_idx[k]] == q_reg1)) fwd_hit1 = 1'b1;
            if (w_live[k] && (q_reg2 != 5'd0) && (r_reg[w_idx[k]] == q_reg2)) fwd_hit2 = 1'b1;
        end
    end

    assign fwd_data1 = 32'd0;
    assign fwd_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios then random traffic, checked against a queue-based model
// with a scoreboard of expected register-file writes drained by an independent monitor.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [4:0]    alu_reg, mem_reg;
    logic [31:0]   alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          RegWrite;
    logic [4:0]    WriteReg;
    logic [31:0]   WriteData;
    logic [4:0]    q_reg1, q_reg2;
    logic          fwd_hit1, fwd_hit2;
    logic [31:0]   fwd_data1, fwd_data2;
    logic [CW-1:0] count;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    ent_t pend[$];
    ent_t sb[$];

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .q_reg1(q_reg1), .q_reg2(q_reg2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void fwd_model(input logic [4:0] q, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (q != 5'd0) begin
            foreach (pend[i]) begin
                if (pend[i].r == q) begin
                    hit = 1'b1;
                    d   = pend[i].d;
                end
            end
        end
`ifndef WB_QUEUE_FWD_EN
        d = 32'd0;
`endif
    endfunction

    // One clock cycle: drive at the falling edge, check settled outputs, then advance the model.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic [4:0] q1, input logic [4:0] q2, input logic r);
        int          cnt;
        logic        e_ar, e_mr, a_acc, m_acc, h1, h2;
        logic [31:0] d1, d2;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        q_reg1 = q1; q_reg2 = q2; rst = r;
        #1;
        cnt  = pend.size();
        e_ar = (cnt < DEPTH);
        e_mr = (cnt <= DEPTH - 2) || ((cnt == DEPTH - 1) && !av);
        fwd_model(q1, h1, d1);
        fwd_model(q2, h2, d2);
        check("count", 32'(count), 32'(cnt));
        check("alu_ready", 32'(alu_ready), 32'(e_ar));
        check("mem_ready", 32'(mem_ready), 32'(e_mr));
        check("RegWrite", 32'(RegWrite), 32'((cnt != 0) && !r));
        check("fwd_hit1", 32'(fwd_hit1), 32'(h1));
        check("fwd_hit2", 32'(fwd_hit2), 32'(h2));
        check("fwd_data1", fwd_data1, d1);
        check("fwd_data2", fwd_data2, d2);
        a_acc = av && e_ar && !r;
        m_acc = mv && e_mr && !r;
        if (r) begin
            pend.delete();
            sb.delete();
        end else begin
            if (cnt != 0) pend.delete(0);
            if (a_acc && ar != 5'd0) begin
                pend.push_back('{r: ar, d: ad});
                sb.push_back('{r: ar, d: ad});
            end
            if (m_acc && mr != 5'd0) begin
                pend.push_back('{r: mr, d: md});
                sb.push_back('{r: mr, d: md});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2, 1'b0);
    endtask

    // Monitor: every presented write must match the oldest expected write.
    initial begin
        ent_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            #2;
            if (RegWrite === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got r%0d=0x%0h expected no write", WriteReg, WriteData);
                end else begin
                    e = sb.pop_front();
                    check("wr_reg", 32'(WriteReg), 32'(e.r));
                    check("wr_data", WriteData, e.d);
                end
            end else begin
                check("idle_reg", 32'(WriteReg), 32'd0);
                check("idle_data", WriteData, 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        q_reg1 = '0; q_reg2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;

        idle(5'd5, 5'd3);
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);

        cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd4, 1'b0);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd0);

        cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        idle(5'd0, 5'd1);

        // Sustained dual-port traffic: saturates the queue and wraps the pointers several times.
        for (int i = 0; i < 12; i++)
            cycle(1'b1, 5'(1 + i % 7), 32'h100 + 32'(i), 1'b1, 5'(2 + i % 5), 32'h200 + 32'(i),
                  5'(1 + i % 7), 5'(2 + i % 5), 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) idle(5'd2, 5'd3);

        cycle(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 5'd7, 5'd8, 1'b0);
        cycle(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'h91, 5'd9, 5'd10, 1'b0);
        cycle(1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0, 5'd11, 5'd12, 1'b1);
        idle(5'd9, 5'd10);
        idle(5'd11, 5'd12);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 59) == 0);

        for (int i = 0; i < DEPTH + 3; i++) idle(5'd1, 5'd2);
        #3;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
